multicycle_control_fsm: RTL
===========================

Name: multicycle_control_fsm

Overview:
Multi-cycle RV32I control sequencer. It replaces the single-cycle decoder path with a state machine that steps the shared datapath through FETCH / DECODE / EXECUTE / MEM / WRITEBACK. It owns the instruction register, handshakes with instruction and data memory (req/ready), and drives every datapath enable. It also counts retired instructions.

Parameters:
RETIRE_W, 32, width of retired-instruction counter (wraps modulo 2^RETIRE_W)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
instr_req  output  1  instruction fetch request, held until instr_ready
instr_ready  input  1  instr_rdata valid this cycle
instr_rdata  input  32  fetched instruction word
ir_o  output  32  latched instruction register, drives imm-gen/regfile addresses
pc_en  output  1  one-cycle PC update strobe
pc_src  output  2  00 PC+4, 01 branch/JAL target, 10 JALR target (rs1+imm)&~1
branch_taken  input  1  comparator result for ir_o, valid in EXECUTE
data_req  output  1  data memory request, held until data_ready
data_we  output  1  1 store, 0 load (valid with data_req)
data_ready  input  1  data access complete
mem_func3  output  3  ir_o[14:12] during MEM (SB/SH/SW, LB/LH/LW/LBU/LHU)
register_write_en  output  1  regfile write strobe
imm_en  output  1  ALU operand B = immediate
alu_control  output  4  {func7[5],func3} encoding (ADD 0000, SUB 1000 ... SRA 1101)
rd_mux_sel  output  3  000 ALU, 001 load, 010 LUI, 011 AUIPC, 100 PC+4
illegal_instr  output  1  sticky, set on unknown opcode/func3
state_o  output  3  current state (debug)
retire_count  output  RETIRE_W  instructions retired since reset

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high. While reset is sampled high: state=IDLE, ir_o=0, retire_count=0, illegal_instr=0.
- Outputs are Moore-style, decoded from state and ir_o. In IDLE every output strobe and request is 0.
- IDLE -> FETCH unconditionally on the first edge after reset deasserts.
- FETCH: instr_req=1. When instr_ready=1, latch ir_o<=instr_rdata and go to DECODE. Otherwise stay, with instr_req held high.
- DECODE: one cycle, no strobes. Unknown opcode, or invalid func3 for load/store/branch: set illegal_instr, go to TRAP. Otherwise go to EXECUTE.
- EXECUTE: drives alu_control and imm_en for the opcode class.
  - Branch: pc_en=1, pc_src=01 if branch_taken else 00, retire, go to FETCH.
  - Load/store: alu_control=ADD, imm_en=1, go to MEM.
  - All other classes: go to WRITEBACK.
- MEM: data_req=1, data_we=store, mem_func3 valid.
  - Wait while data_ready=0, with all signals held stable.
  - Store with data_ready: pc_en=1, pc_src=00, retire, go to FETCH.
  - Load with data_ready: go to WRITEBACK.
- WRITEBACK: register_write_en=1 for exactly one cycle, rd_mux_sel per class, pc_en=1, retire, go to FETCH.
  - pc_src is 01 for JAL, 10 for JALR, 00 otherwise.
  - rd_mux uses the pre-update PC; the PC register changes at the end of this cycle.
- TRAP: absorbing state. All strobes 0, illegal_instr=1. Left only by reset.
- alu_control decoding:
  - R-type: {ir[30],func3}; undefined combinations map to ADD.
  - OP-IMM: ir[30] is honoured only for func3=101, otherwise forced 0.
  - LUI, AUIPC, JAL, JALR, load, store: ADD.
- Latency with zero-wait memory (ready in the same cycle as req):
  - Branch: 3 cycles.
  - R/I/LUI/AUIPC/JAL/JALR: 4 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
  - Each wait cycle on memory adds one cycle.
- Retire: retire_count increments on the cycle pc_en=1, exactly once per instruction, and wraps to 0.
- Reset mid-operation: any state returns to IDLE on the next edge. A pending req is dropped (the memory must tolerate request withdrawal). No register_write_en or pc_en is issued during or after the reset cycle.
- x1/x0 rules: writes with rd=x0 are still strobed; the regfile ignores them.

Decomposition:
- Package rv32i_ctrl_pkg:
  - opcode constants.
  - alu_control enum.
  - rd_mux_sel and pc_src encodings.
  - state enum: IDLE, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, TRAP.
  - opcode-class enum.
- One sub-module, rv32i_instr_class: combinational. Takes ir_o and produces class, alu_control, imm_en, rd_mux_sel and legal.
- The FSM, IR and counter live in the top module.

Test Plan:
- Reset then ADD x3,x1,x2 (0x002081B3), ready always 1 -> instr_req cycle 1; register_write_en=1, rd_mux_sel=000, alu_control=0000 on cycle 4; retire_count=1.
- LW x5,4(x1) (0x0040A283), data_ready delayed 2 cycles -> data_req high 3 cycles, data_we=0, mem_func3=010; WB one cycle later with rd_mux_sel=001; total 7 cycles.
- BEQ (0x00208463) with branch_taken=1, then with branch_taken=0 -> pc_en in EXECUTE with pc_src=01, then 00; register_write_en never asserted.
- SW x2,8(x1) (0x0020A423) -> data_req=1 and data_we=1; pc_en coincides with data_ready; no regfile write.
- JALR x1,0(x5) (0x000280E7) -> WB: register_write_en=1, rd_mux_sel=100, pc_src=10.
- Opcode 0x0000007F -> TRAP after DECODE, illegal_instr=1 and stays; reset asserted in the MEM wait of a load -> IDLE, no write strobe, retire_count=0.

Source files
------------

// File: rtl/rv32i_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control sequencer:
// opcodes, ALU control, rd/pc mux selects, FSM states and opcode classes.
package rv32i_ctrl_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_SUB  = 4'b1000,
    ALU_SRA  = 4'b1101
  } alu_ctrl_e;

  localparam logic [2:0] RD_ALU   = 3'b000;
  localparam logic [2:0] RD_LOAD  = 3'b001;
  localparam logic [2:0] RD_LUI   = 3'b010;
  localparam logic [2:0] RD_AUIPC = 3'b011;
  localparam logic [2:0] RD_PC4   = 3'b100;

  localparam logic [1:0] PC_SRC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_SRC_TARGET = 2'b01;
  localparam logic [1:0] PC_SRC_JALR   = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEM       = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_TRAP      = 3'd6
  } state_e;

  typedef enum logic [3:0] {
    CLS_OP, CLS_OPIMM, CLS_LOAD, CLS_STORE, CLS_BRANCH,
    CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR, CLS_ILLEGAL
  } op_class_e;

endpackage

// File: rtl/rv32i_instr_class.sv
// Combinational instruction classifier: opcode class, ALU control,
// immediate-operand select, writeback source and legality from the IR.
module rv32i_instr_class
  import rv32i_ctrl_pkg::*;
(
  input  logic [31:0] ir,
  output op_class_e   op_class,
  output alu_ctrl_e   alu_control,
  output logic        imm_en,
  output logic [2:0]  rd_mux_sel,
  output logic        legal
);

  logic [2:0] f3;
  logic       unused_bits;

  assign f3          = ir[14:12];
  assign unused_bits = ^{ir[31], ir[29:15], ir[11:7]};

  always_comb begin
    op_class    = CLS_ILLEGAL;
    alu_control = ALU_ADD;
    imm_en      = 1'b0;
    rd_mux_sel  = RD_ALU;
    legal       = 1'b1;
    case (ir[6:0])
      OPC_OP: begin
        op_class = CLS_OP;
        // Only real R-type encodings pass through; the rest fall back to ADD.
        case ({ir[30], f3})
          4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101,
          4'b0110, 4'b0111, 4'b1000, 4'b1101: alu_control = alu_ctrl_e'({ir[30], f3});
          default:                            alu_control = ALU_ADD;
        endcase
      end
      OPC_OPIMM: begin
        op_class    = CLS_OPIMM;
        imm_en      = 1'b1;
        alu_control = alu_ctrl_e'({ir[30] & (f3 == 3'b101), f3});
      end
      OPC_LOAD: begin
        op_class   = CLS_LOAD;
        imm_en     = 1'b1;
        rd_mux_sel = RD_LOAD;
        legal      = f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      end
      OPC_STORE: begin
        op_class = CLS_STORE;
        imm_en   = 1'b1;
        legal    = f3 inside {3'b000, 3'b001, 3'b010};
      end
      OPC_BRANCH: begin
        op_class    = CLS_BRANCH;
        alu_control = ALU_SUB;
        legal       = !(f3 inside {3'b010, 3'b011});
      end
      OPC_LUI: begin
        op_class   = CLS_LUI;
        imm_en     = 1'b1;
        rd_mux_sel = RD_LUI;
      end
      OPC_AUIPC: begin
        op_class   = CLS_AUIPC;
        imm_en     = 1'b1;
        rd_mux_sel = RD_AUIPC;
      end
      OPC_JAL: begin
        op_class   = CLS_JAL;
        imm_en     = 1'b1;
        rd_mux_sel = RD_PC4;
      end
      OPC_JALR: begin
        op_class   = CLS_JALR;
        imm_en     = 1'b1;
        rd_mux_sel = RD_PC4;
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXECUTE/MEM/WRITEBACK
// state machine owning the IR, memory handshakes, datapath enables and retire count.
module multicycle_control_fsm
  import rv32i_ctrl_pkg::*;
#(
  parameter int RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  output logic                instr_req,
  input  logic                instr_ready,
  input  logic [31:0]         instr_rdata,
  output logic [31:0]         ir_o,
  output logic                pc_en,
  output logic [1:0]          pc_src,
  input  logic                branch_taken,
  output logic                data_req,
  output logic                data_we,
  input  logic                data_ready,
  output logic [2:0]          mem_func3,
  output logic                register_write_en,
  output logic                imm_en,
  output logic [3:0]          alu_control,
  output logic [2:0]          rd_mux_sel,
  output logic                illegal_instr,
  output logic [2:0]          state_o,
  output logic [RETIRE_W-1:0] retire_count
);

  state_e              state_q;
  logic [31:0]         ir_q;
  logic [RETIRE_W-1:0] retire_q;
  logic                illegal_q;

  op_class_e  cls;
  alu_ctrl_e  dec_alu;
  logic       dec_imm;
  logic [2:0] dec_rd;
  logic       dec_legal;

  rv32i_instr_class u_class (
    .ir          (ir_q),
    .op_class    (cls),
    .alu_control (dec_alu),
    .imm_en      (dec_imm),
    .rd_mux_sel  (dec_rd),
    .legal       (dec_legal)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ir_q      <= '0;
      retire_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      if (pc_en) retire_q <= retire_q + RETIRE_W'(1);
      case (state_q)
        ST_IDLE:  state_q <= ST_FETCH;
        ST_FETCH: if (instr_ready) begin
          ir_q    <= instr_rdata;
          state_q <= ST_DECODE;
        end
        ST_DECODE: if (!dec_legal) begin
          illegal_q <= 1'b1;
          state_q   <= ST_TRAP;
        end else begin
          state_q <= ST_EXECUTE;
        end
        ST_EXECUTE: begin
          if (cls == CLS_BRANCH)                         state_q <= ST_FETCH;
          else if (cls == CLS_LOAD || cls == CLS_STORE)  state_q <= ST_MEM;
          else                                           state_q <= ST_WRITEBACK;
        end
        ST_MEM: if (data_ready) state_q <= (cls == CLS_STORE) ? ST_FETCH : ST_WRITEBACK;
        ST_WRITEBACK: state_q <= ST_FETCH;
        ST_TRAP:      state_q <= ST_TRAP;
        default:      state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    instr_req         = 1'b0;
    pc_en             = 1'b0;
    pc_src            = PC_SRC_PLUS4;
    data_req          = 1'b0;
    data_we           = 1'b0;
    mem_func3         = 3'b000;
    register_write_en = 1'b0;
    imm_en            = 1'b0;
    alu_control       = ALU_ADD;
    rd_mux_sel        = RD_ALU;
    case (state_q)
      ST_FETCH: instr_req = 1'b1;
      ST_EXECUTE: begin
        alu_control = dec_alu;
        imm_en      = dec_imm;
        if (cls == CLS_BRANCH) begin
          pc_en  = 1'b1;
          pc_src = branch_taken ? PC_SRC_TARGET : PC_SRC_PLUS4;
        end
      end
      ST_MEM: begin
        alu_control = dec_alu;
        imm_en      = dec_imm;
        data_req    = 1'b1;
        data_we     = (cls == CLS_STORE);
        mem_func3   = ir_q[14:12];
        pc_en       = data_ready && (cls == CLS_STORE);
      end
      ST_WRITEBACK: begin
        alu_control       = dec_alu;
        imm_en            = dec_imm;
        register_write_en = 1'b1;
        rd_mux_sel        = dec_rd;
        pc_en             = 1'b1;
        if (cls == CLS_JAL)       pc_src = PC_SRC_TARGET;
        else if (cls == CLS_JALR) pc_src = PC_SRC_JALR;
      end
      default: ;
    endcase
    // A reset cycle must never commit a write, a PC update or a new request.
    if (reset) begin
      instr_req         = 1'b0;
      data_req          = 1'b0;
      pc_en             = 1'b0;
      register_write_en = 1'b0;
    end
  end

  assign ir_o          = ir_q;
  assign illegal_instr = illegal_q;
  assign state_o       = state_q;
  assign retire_count  = retire_q;

endmodule
